// File: rtl/pwm_capture.sv
// Measures period (rise to rise) and high time of an asynchronous PWM input in clock cycles.
// Reports one measurement per complete period and flags a line stuck for MAX cycles as a timeout.
module pwm_capture #(
   parameter int CNT_BITS    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                pwm_in,
   output logic [CNT_BITS-1:0] period,
   output logic [CNT_BITS-1:0] high_time,
   output logic                valid,
   output logic                timeout,
   output logic                level
);

   localparam logic [CNT_BITS-1:0] MAX = '1;
   localparam logic [CNT_BITS-1:0] ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t                state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                  s_prev_q, s_prev_d;
   logic [CNT_BITS-1:0]   cnt_per_q, cnt_per_d;
   logic [CNT_BITS-1:0]   cnt_hi_q, cnt_hi_d;
   logic [CNT_BITS-1:0]   period_q, period_d;
   logic [CNT_BITS-1:0]   high_time_q, high_time_d;
   logic                  valid_q, valid_d;
   logic                  timeout_q, timeout_d;
   logic                  level_q, level_d;
   logic                  s, rise, fall;

   // Holds at MAX so a fall landing exactly on MAX cannot wrap the period count.
   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
      return (v == MAX) ? v : v + ONE;
   endfunction

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_prev_q;
   assign fall = ~s & s_prev_q;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_prev_d = s;
   end

   always_comb begin
      state_d     = state_q;
      cnt_per_d   = cnt_per_q;
      cnt_hi_d    = cnt_hi_q;
      period_d    = period_q;
      high_time_d = high_time_q;
      valid_d     = 1'b0;
      timeout_d   = timeout_q;
      level_d     = level_q;

      if (!en) begin
         state_d   = IDLE;
         cnt_per_d = '0;
         cnt_hi_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise) begin
                  state_d   = HIGH;
                  cnt_per_d = ONE;
                  cnt_hi_d  = ONE;
                  timeout_d = 1'b0;
               end
            end
            HIGH: begin
               if (fall) begin
                  state_d   = LOW;
                  cnt_per_d = sat_inc(cnt_per_q);
               end else if (cnt_per_q == MAX) begin
                  state_d   = IDLE;
                  cnt_per_d = '0;
                  cnt_hi_d  = '0;
                  timeout_d = 1'b1;
                  level_d   = s;
               end else begin
                  cnt_per_d = sat_inc(cnt_per_q);
                  cnt_hi_d  = sat_inc(cnt_hi_q);
               end
            end
            LOW: begin
               if (rise) begin
                  state_d     = HIGH;
                  period_d    = cnt_per_q;
                  high_time_d = cnt_hi_q;
                  valid_d     = 1'b1;
                  cnt_per_d   = ONE;
                  cnt_hi_d    = ONE;
               end else if (cnt_per_q == MAX) begin
                  state_d   = IDLE;
                  cnt_per_d = '0;
                  cnt_hi_d  = '0;
                  timeout_d = 1'b1;
                  level_d   = s;
               end else begin
                  cnt_per_d = sat_inc(cnt_per_q);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Synchronizer and edge history reset high so a line already high at reset is not a rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sync_q      <= '1;
         s_prev_q    <= 1'b1;
         cnt_per_q   <= '0;
         cnt_hi_q    <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         valid_q     <= 1'b0;
         timeout_q   <= 1'b0;
         level_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         s_prev_q    <= s_prev_d;
         cnt_per_q   <= cnt_per_d;
         cnt_hi_q    <= cnt_hi_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
         valid_q     <= valid_d;
         timeout_q   <= timeout_d;
         level_q     <= level_d;
      end
   end

   assign period    = period_q;
   assign high_time = high_time_q;
   assign valid     = valid_q;
   assign timeout   = timeout_q;
   assign level     = level_q;

endmodule
